// File: rtl/score_keeper.sv
// score_keeper: multi-team basketball score accumulator. Debounces every button,
// combines simultaneous presses into a saturating net delta, keeps one undo level.
module score_keeper #(
   parameter int NUM_TEAMS       = 2,
   parameter int SCORE_W         = 11,
   parameter int MAX_SCORE       = 1999,
   parameter int DEBOUNCE_CYCLES = 400000
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_TEAMS*6-1:0]         btn_n,
   input  logic [NUM_TEAMS-1:0]           undo_n,
   output logic [NUM_TEAMS*SCORE_W-1:0]   score,
   output logic [NUM_TEAMS-1:0]           evt_valid,
   output logic [NUM_TEAMS*4-1:0]         evt_delta
);

   localparam int NB = NUM_TEAMS * 7;
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int XW = SCORE_W + 2;
   localparam logic [CW-1:0]        DB_MAX = CW'(DEBOUNCE_CYCLES);
   localparam logic signed [XW-1:0] MAX_X  = XW'(MAX_SCORE);
   localparam logic [SCORE_W-1:0]   MAX_S  = SCORE_W'(MAX_SCORE);

   // Bits [6N-1:0] are score buttons, bits [7N-1:6N] are the per-team undo buttons.
   logic [NB-1:0] w_raw;
   logic [NB-1:0] r_sync1;
   logic [NB-1:0] r_sync2;
   logic [NB-1:0] r_stable;
   logic [NB-1:0] r_last;
   logic [NB-1:0] w_press;
   logic [CW-1:0] r_cnt [NB];

   logic [NUM_TEAMS-1:0][SCORE_W-1:0] r_score;
   logic [NUM_TEAMS-1:0][SCORE_W-1:0] w_next;
   logic [NUM_TEAMS-1:0][3:0]         r_hist;
   logic [NUM_TEAMS-1:0][3:0]         r_evt_delta;
   logic [NUM_TEAMS-1:0][3:0]         w_delta;
   logic [NUM_TEAMS-1:0]              r_hist_v;
   logic [NUM_TEAMS-1:0]              r_evt_valid;
   logic [NUM_TEAMS-1:0]              w_evt;
   logic [NUM_TEAMS-1:0]              w_undo;

   function automatic logic signed [3:0] net_delta(input logic [5:0] p);
      net_delta = (p[0] ? 4'sd1 : 4'sd0) + (p[1] ? 4'sd2 : 4'sd0) + (p[2] ? 4'sd3 : 4'sd0)
                - (p[3] ? 4'sd1 : 4'sd0) - (p[4] ? 4'sd2 : 4'sd0) - (p[5] ? 4'sd3 : 4'sd0);
   endfunction

   // Two extra bits keep score+net free of wrap before the clamp.
   function automatic logic [SCORE_W-1:0] clamp_score(input logic [SCORE_W-1:0] cur,
                                                      input logic signed [3:0] net);
      logic signed [XW-1:0] sum;
      sum = $signed({2'b00, cur}) + $signed({{(XW-4){net[3]}}, net});
      if (sum[XW-1]) begin
         clamp_score = '0;
      end else if (sum > MAX_X) begin
         clamp_score = MAX_S;
      end else begin
         clamp_score = sum[SCORE_W-1:0];
      end
   endfunction

   assign w_raw   = {undo_n, btn_n};
   assign w_press = r_stable & ~r_last;

   // Synchroniser, per-bit debounce counter and press-edge history.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1  <= '1;
         r_sync2  <= '1;
         r_stable <= '0;
         r_last   <= '0;
         for (int i = 0; i < NB; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         r_last  <= r_stable;
         for (int i = 0; i < NB; i++) begin
            if (r_sync2[i]) begin
               r_cnt[i]    <= '0;
               r_stable[i] <= 1'b0;
            end else if (r_cnt[i] == DB_MAX) begin
               r_stable[i] <= 1'b1;
            end else begin
               r_cnt[i] <= r_cnt[i] + CW'(1);
            end
         end
      end
   end

   // Per-team next score: a valid undo wins over (and discards) same-cycle presses.
   always_comb begin
      w_next  = r_score;
      w_delta = '0;
      w_evt   = '0;
      w_undo  = '0;
      for (int t = 0; t < NUM_TEAMS; t++) begin
         if (w_press[6*NUM_TEAMS+t] && r_hist_v[t]) begin
            w_undo[t]  = 1'b1;
            w_evt[t]   = 1'b1;
            w_next[t]  = r_score[t] - {{(SCORE_W-4){r_hist[t][3]}}, r_hist[t]};
            w_delta[t] = 4'b0000 - r_hist[t];
         end else begin
            w_next[t]  = clamp_score(r_score[t], net_delta(w_press[6*t +: 6]));
            w_delta[t] = 4'(w_next[t] - r_score[t]);
            w_evt[t]   = (w_next[t] != r_score[t]);
         end
      end
   end

   // Score, event and undo-history registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_score     <= '0;
         r_hist      <= '0;
         r_hist_v    <= '0;
         r_evt_valid <= '0;
         r_evt_delta <= '0;
      end else begin
         r_score     <= w_next;
         r_evt_valid <= w_evt;
         for (int t = 0; t < NUM_TEAMS; t++) begin
            r_evt_delta[t] <= w_evt[t] ? w_delta[t] : 4'b0000;
            if (w_undo[t]) begin
               r_hist_v[t] <= 1'b0;
            end else if (w_evt[t]) begin
               r_hist[t]   <= w_delta[t];
               r_hist_v[t] <= 1'b1;
            end else begin
               r_hist_v[t] <= r_hist_v[t];
            end
         end
      end
   end

   assign score     = r_score;
   assign evt_valid = r_evt_valid;
   assign evt_delta = r_evt_delta;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed scenarios plus random presses against a
// run-length / arithmetic reference model of the scoreboard.
module tb_score_keeper;
   localparam int NT   = 2;
   localparam int SW   = 11;
   localparam int MAXS = 20;
   localparam int DB   = 4;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic [11:0]    btn_n = '1;
   logic [1:0]     undo_n = '1;
   logic [21:0]    score;
   logic [1:0]     evt_valid;
   logic [7:0]     evt_delta;

   int total = 0;
   int bad   = 0;

   // reference model state
   int         run [14];
   logic [13:0] pipe0, pipe1, pipe2;
   int         m_score [2];
   int         m_hist [2];
   bit         m_hv [2];
   bit         m_evt [2];
   int         m_delta [2];

   int obs_cnt [2];
   int obs_delta [2];
   bit obs_both;

   score_keeper #(.NUM_TEAMS(NT), .SCORE_W(SW), .MAX_SCORE(MAXS), .DEBOUNCE_CYCLES(DB)) dut (
      .clk(clk), .reset(reset), .btn_n(btn_n), .undo_n(undo_n),
      .score(score), .evt_valid(evt_valid), .evt_delta(evt_delta));

   always #5 clk = ~clk;

   function automatic int dut_score(input int t);
      logic [SW-1:0] s;
      s = score[t*SW +: SW];
      return int'(s);
   endfunction

   function automatic int dut_delta(input int t);
      logic signed [3:0] d;
      d = evt_delta[t*4 +: 4];
      return int'(d);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 14; i++) run[i] = 0;
      pipe0 = '0; pipe1 = '0; pipe2 = '0;
      for (int t = 0; t < 2; t++) begin
         m_score[t] = 0; m_hist[t] = 0; m_hv[t] = 0; m_evt[t] = 0; m_delta[t] = 0;
      end
   endtask

   // A button counts as pressed once it has been seen low on DB+1 consecutive
   // edges; the score reflects that press three edges later.
   task automatic model_apply(input logic [13:0] app);
      int net, nxt;
      for (int t = 0; t < 2; t++) begin
         m_evt[t] = 0;
         if (app[12+t] && m_hv[t]) begin
            m_score[t] = m_score[t] - m_hist[t];
            m_delta[t] = -m_hist[t];
            m_evt[t]   = 1;
            m_hv[t]    = 0;
         end else begin
            net = 0;
            if (app[6*t+0]) net += 1;
            if (app[6*t+1]) net += 2;
            if (app[6*t+2]) net += 3;
            if (app[6*t+3]) net -= 1;
            if (app[6*t+4]) net -= 2;
            if (app[6*t+5]) net -= 3;
            nxt = m_score[t] + net;
            if (nxt < 0) nxt = 0;
            if (nxt > MAXS) nxt = MAXS;
            if (nxt != m_score[t]) begin
               m_evt[t]   = 1;
               m_delta[t] = nxt - m_score[t];
               m_hist[t]  = nxt - m_score[t];
               m_hv[t]    = 1;
            end
            m_score[t] = nxt;
         end
      end
   endtask

   task automatic step(input logic [11:0] b, input logic [1:0] u);
      logic [13:0] raw, det, app;
      btn_n  = b;
      undo_n = u;
      @(posedge clk);
      raw = {u, b};
      det = '0;
      for (int i = 0; i < 14; i++) begin
         if (!raw[i]) begin
            run[i]++;
            if (run[i] == DB + 1) det[i] = 1'b1;
         end else begin
            run[i] = 0;
         end
      end
      app   = pipe2;
      pipe2 = pipe1;
      pipe1 = pipe0;
      pipe0 = det;
      model_apply(app);
      #1;
   endtask

   // Holds the masked buttons low for 'hold' cycles then idles; records events seen.
   task automatic press(input logic [11:0] m, input logic [1:0] um, input int hold);
      obs_cnt[0] = 0; obs_cnt[1] = 0; obs_both = 0;
      obs_delta[0] = 0; obs_delta[1] = 0;
      for (int i = 0; i < hold + 8; i++) begin
         step((i < hold) ? ~m : 12'hFFF, (i < hold) ? ~um : 2'b11);
         for (int t = 0; t < 2; t++) begin
            if (evt_valid[t] === 1'b1) begin
               obs_cnt[t]++;
               obs_delta[t] = dut_delta(t);
            end
         end
         if (evt_valid === 2'b11) obs_both = 1;
      end
   endtask

   task automatic assert_reset();
      @(negedge clk);
      reset = 1'b0;
      model_clear();
   endtask

   task automatic release_reset();
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      model_clear();
      #3;
      total += 3;
      if (score !== 22'd0) begin bad++; $display("FAIL reset_score got=%h exp=0", score); end
      if (evt_valid !== 2'b00) begin bad++; $display("FAIL reset_evt got=%b exp=00", evt_valid); end
      if (evt_delta !== 8'd0) begin bad++; $display("FAIL reset_delta got=%h exp=0", evt_delta); end
      release_reset();
   endtask

   task automatic test_hold();
      logic [SW-1:0] s0;
      int pulses = 0;
      for (int i = 0; i < 20; i++) begin
         step(12'hFFE, 2'b11);
         s0 = score[SW-1:0];
         total++;
         if (s0 !== SW'((i >= 7) ? 1 : 0)) begin
            bad++; $display("FAIL hold_score edge=%0d got=%0d exp=%0d", i + 1, s0, (i >= 7) ? 1 : 0);
         end
         if (evt_valid[0] === 1'b1) begin
            pulses++;
            total++;
            if (i != 7 || dut_delta(0) != 1) begin
               bad++; $display("FAIL hold_evt edge=%0d delta=%0d exp edge=8 delta=1", i + 1, dut_delta(0));
            end
         end
      end
      total++;
      if (pulses != 1) begin bad++; $display("FAIL hold_pulses got=%0d exp=1", pulses); end
      repeat (6) step(12'hFFF, 2'b11);
   endtask

   task automatic test_glitch();
      press(12'h004, 2'b00, 3);
      total += 2;
      if (obs_cnt[0] != 0) begin bad++; $display("FAIL glitch_evt got=%0d exp=0", obs_cnt[0]); end
      if (dut_score(0) != 1) begin bad++; $display("FAIL glitch_score got=%0d exp=1", dut_score(0)); end
      press(12'h004, 2'b00, 6);
      total += 3;
      if (dut_score(0) != 4) begin bad++; $display("FAIL plus3_score got=%0d exp=4", dut_score(0)); end
      if (obs_cnt[0] != 1) begin bad++; $display("FAIL plus3_evt got=%0d exp=1", obs_cnt[0]); end
      if (obs_delta[0] != 3) begin bad++; $display("FAIL plus3_delta got=%0d exp=3", obs_delta[0]); end
   endtask

   task automatic test_combine();
      press(12'h001, 2'b00, 6);
      press(12'h00C, 2'b00, 6);
      total += 3;
      if (dut_score(0) != 7) begin bad++; $display("FAIL combine_score got=%0d exp=7", dut_score(0)); end
      if (obs_cnt[0] != 1) begin bad++; $display("FAIL combine_evt got=%0d exp=1", obs_cnt[0]); end
      if (obs_delta[0] != 2) begin bad++; $display("FAIL combine_delta got=%0d exp=2", obs_delta[0]); end
   endtask

   task automatic test_saturate();
      for (int k = 0; k < 6; k++) press(12'h100, 2'b00, 6);
      press(12'h040, 2'b00, 6);
      total++;
      if (dut_score(1) != 19) begin bad++; $display("FAIL sat_setup got=%0d exp=19", dut_score(1)); end
      press(12'h100, 2'b00, 6);
      total += 2;
      if (dut_score(1) != 20) begin bad++; $display("FAIL sat_top_score got=%0d exp=20", dut_score(1)); end
      if (obs_delta[1] != 1) begin bad++; $display("FAIL sat_top_delta got=%0d exp=1", obs_delta[1]); end
      press(12'h080, 2'b00, 6);
      total += 2;
      if (dut_score(1) != 20) begin bad++; $display("FAIL sat_hold_score got=%0d exp=20", dut_score(1)); end
      if (obs_cnt[1] != 0) begin bad++; $display("FAIL sat_hold_evt got=%0d exp=0", obs_cnt[1]); end
      for (int k = 0; k < 6; k++) press(12'h800, 2'b00, 6);
      press(12'h800, 2'b00, 6);
      total += 2;
      if (dut_score(1) != 0) begin bad++; $display("FAIL sat_low_score got=%0d exp=0", dut_score(1)); end
      if (obs_delta[1] != -2) begin bad++; $display("FAIL sat_low_delta got=%0d exp=-2", obs_delta[1]); end
   endtask

   task automatic test_undo();
      press(12'h002, 2'b00, 6);
      total++;
      if (dut_score(0) != 9) begin bad++; $display("FAIL undo_setup got=%0d exp=9", dut_score(0)); end
      press(12'h000, 2'b01, 6);
      total += 2;
      if (dut_score(0) != 7) begin bad++; $display("FAIL undo_score got=%0d exp=7", dut_score(0)); end
      if (obs_delta[0] != -2) begin bad++; $display("FAIL undo_delta got=%0d exp=-2", obs_delta[0]); end
      press(12'h000, 2'b01, 6);
      total += 2;
      if (dut_score(0) != 7) begin bad++; $display("FAIL undo2_score got=%0d exp=7", dut_score(0)); end
      if (obs_cnt[0] != 0) begin bad++; $display("FAIL undo2_evt got=%0d exp=0", obs_cnt[0]); end
      press(12'h001, 2'b00, 6);
      press(12'h001, 2'b01, 6);
      total += 3;
      if (dut_score(0) != 7) begin bad++; $display("FAIL undo_prio_score got=%0d exp=7", dut_score(0)); end
      if (obs_cnt[0] != 1) begin bad++; $display("FAIL undo_prio_evt got=%0d exp=1", obs_cnt[0]); end
      if (obs_delta[0] != -1) begin bad++; $display("FAIL undo_prio_delta got=%0d exp=-1", obs_delta[0]); end
   endtask

   task automatic test_both_teams();
      press(12'h081, 2'b00, 6);
      total += 3;
      if (dut_score(0) != 8) begin bad++; $display("FAIL both_score0 got=%0d exp=8", dut_score(0)); end
      if (dut_score(1) != 2) begin bad++; $display("FAIL both_score1 got=%0d exp=2", dut_score(1)); end
      if (!obs_both) begin bad++; $display("FAIL both_evt got=%0d exp=1", obs_both); end
   endtask

   task automatic test_reset_mid();
      logic [SW-1:0] s0;
      int pulses = 0;
      repeat (3) step(12'hFFE, 2'b11);
      assert_reset();
      #1;
      total += 3;
      if (score !== 22'd0) begin bad++; $display("FAIL mid_reset_score got=%h exp=0", score); end
      if (evt_valid !== 2'b00) begin bad++; $display("FAIL mid_reset_evt got=%b exp=00", evt_valid); end
      if (evt_delta !== 8'd0) begin bad++; $display("FAIL mid_reset_delta got=%h exp=0", evt_delta); end
      btn_n = '1;
      release_reset();
      for (int i = 0; i < 16; i++) begin
         step(12'hFFF, 2'b11);
         if (evt_valid !== 2'b00) pulses++;
      end
      total += 2;
      if (pulses != 0) begin bad++; $display("FAIL mid_reset_spurious got=%0d exp=0", pulses); end
      if (score !== 22'd0) begin bad++; $display("FAIL mid_reset_after got=%h exp=0", score); end
      // button held through reset release must debounce afresh
      btn_n = 12'hFFE;
      assert_reset();
      release_reset();
      for (int i = 0; i < 12; i++) begin
         step(12'hFFE, 2'b11);
         s0 = score[SW-1:0];
         total++;
         if (s0 !== SW'((i >= 7) ? 1 : 0)) begin
            bad++; $display("FAIL held_reset edge=%0d got=%0d exp=%0d", i + 1, s0, (i >= 7) ? 1 : 0);
         end
      end
      repeat (6) step(12'hFFF, 2'b11);
   endtask

   task automatic test_random();
      logic [11:0] m;
      logic [1:0]  um;
      int hold, idle;
      for (int it = 0; it < 60; it++) begin
         m    = 12'($urandom_range(0, 4095));
         um   = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
         hold = $urandom_range(2, 8);
         idle = $urandom_range(0, 5);
         for (int c = 0; c < hold + idle + 3; c++) begin
            if (c < hold) step(~m, ~um);
            else step(12'hFFF, 2'b11);
            for (int t = 0; t < 2; t++) begin
               total += 2;
               if (dut_score(t) != m_score[t]) begin
                  bad++; $display("FAIL rand_score it=%0d t=%0d got=%0d exp=%0d", it, t, dut_score(t), m_score[t]);
               end
               if (evt_valid[t] !== m_evt[t]) begin
                  bad++; $display("FAIL rand_evt it=%0d t=%0d got=%b exp=%0d", it, t, evt_valid[t], m_evt[t]);
               end
               if (m_evt[t] && evt_valid[t] === 1'b1) begin
                  total++;
                  if (dut_delta(t) != m_delta[t]) begin
                     bad++; $display("FAIL rand_delta it=%0d t=%0d got=%0d exp=%0d", it, t, dut_delta(t), m_delta[t]);
                  end
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_hold();
      test_glitch();
      test_combine();
      test_saturate();
      test_undo();
      test_both_teams();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Parametrised multi-team basketball score accumulator; successor of the single-team score adder.
- Each team has six active-low buttons (+1, +2, +3, -1, -2, -3) and one undo button. The block synchronises and debounces every button and detects each press.
- Simultaneous presses for a team are combined into one net delta. Scores saturate in the range [0, MAX_SCORE], and each team has a single-level undo.
- Sits between the board push-buttons and the score display/BCD conversion logic. It also emits per-team change events for a future game-log block.

Parameters:
- NUM_TEAMS, 2, number of independent team scores (>=1)
- SCORE_W, 11, width of each score field
- MAX_SCORE, 1999, upper saturation limit (must be < 2**SCORE_W)
- DEBOUNCE_CYCLES, 400000, consecutive synchronised-low cycles required to accept a press (>=1)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- btn_n  input  NUM_TEAMS*6  raw active-low score buttons; team t uses bits 6t+0..6t+5 = +1,+2,+3,-1,-2,-3
- undo_n  input  NUM_TEAMS  raw active-low undo button per team
- score  output  NUM_TEAMS*SCORE_W  team t score at bits [t*SCORE_W +: SCORE_W]
- evt_valid  output  NUM_TEAMS  1-cycle pulse per team when its score changes
- evt_delta  output  NUM_TEAMS*4  signed applied change per team (-6..+6); valid only with evt_valid[t]

Behaviour:
- Reset is asynchronous active-low on reset; clock is clk.
- Reset values:
  - score = 0, evt_valid = 0, evt_delta = 0
  - all synchroniser flops = 1 (released), all debounce counters = 0
  - all stable/last flags = 0, undo history empty
- Per input bit: 2-FF synchroniser, then debounce counter.
  - Counter increments while the synchronised level is 0.
  - When the counter reaches DEBOUNCE_CYCLES, stable goes to 1 and the counter holds.
  - A synchronised 1 clears the counter and stable immediately.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Press pulse = stable & ~stable_last (1 cycle), so there is one press per physical press regardless of hold time.
- Latency: from the raw input going low and staying low, the score and evt outputs update exactly DEBOUNCE_CYCLES+4 clk edges later.
- Score update, per team, each cycle:
  - net = sum of press deltas for that team this cycle (range -6..+6, signed 4-bit).
  - next = clamp(score + net, 0, MAX_SCORE), computed in SCORE_W+2 signed bits; no wrap-around ever.
  - applied = next - score. If applied != 0: score <= next, evt_valid[t] = 1, evt_delta[t] = applied, history[t] <= applied, history_valid[t] <= 1.
  - If applied == 0 (net 0 or saturated): no score change, no event, history unchanged.
- Undo, per team:
  - An undo press with history_valid[t] = 1 sets score <= score - history[t], evt_delta = -history[t], evt_valid = 1, and history_valid <= 0 (single level; a second undo is ignored).
  - An undo press with no history is ignored.
  - An undo press in the same cycle as score presses for that team takes priority; those score presses are discarded (not queued).
- Teams are fully independent: simultaneous events on different teams all apply in the same cycle.
- Reset asserted mid-operation clears everything immediately. A button held through reset release is accepted as a new press after the full debounce.

Test Plan:
(Bench settings: NUM_TEAMS=2, SCORE_W=11, MAX_SCORE=20, DEBOUNCE_CYCLES=4.)
- Hold btn_n[0] (team0 +1) low for 20 cycles from reset -> score0 goes 0->1 exactly 8 edges after the fall; one evt_valid[0] pulse with evt_delta=+1; no further increment while held.
- Glitch btn_n[2] low for 3 cycles, then high -> no score change, no event. Repeat with a 6-cycle hold -> score0 +3.
- Press team0 +3 and -1 aligned in the same cycle, starting from score 5 -> score0 = 7, single event with delta=+2.
- Team1 at 19, press +3 -> score1 = 20, delta=+1. Press +2 -> no change, no event. Then -3 from 2 -> 0, delta=-2.
- Team0 at 7, press +2 (9), then undo -> 7 with delta=-2. Second undo -> ignored. Undo and +1 pressed together with history set -> undo only.
- Team0 +1 and team1 +2 in the same cycle -> both scores update, evt_valid=2'b11. Assert reset mid-debounce -> all outputs 0 and no spurious press after release.
